edge_frame_writer: RTL and testbench
====================================

# edge_frame_writer

Sink end of the edge-detection pixel stream. Accepts binary edge pixels in raster order from the `canny_advanced` output stage over a valid/ready handshake. Packs them eight per byte, LSB first, and writes each byte into the edge-map frame RAM. Reports per-frame completion, framing errors and the number of edge pixels in the frame.

## Interface
- `IMG_W`, 64: pixels per line; must be a multiple of 8.
- `IMG_H`, 64: lines per frame.
- `ADDR_W`, 9: frame RAM byte-address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H/8.
- `CNT_W`, 13: edge counter width; must satisfy 2^CNT_W > IMG_W*IMG_H.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pixel beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_edge`  in  1  edge pixel value (1 = edge).
- `in_sof`  in  1  first pixel of a frame.
- `in_eol`  in  1  last pixel of a line.
- `mem_we`  out  1  frame RAM write strobe.
- `mem_addr`  out  ADDR_W  frame RAM byte address.
- `mem_wdata`  out  8  packed byte.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `frame_err`  out  1  sticky framing error for the current or last frame.
- `edge_count`  out  CNT_W  number of 1-pixels in the current or last frame.

## Operation
- A beat is accepted when `in_valid && in_ready` is true at a rising edge.
- Reset value of every output is 0.
- State after reset:
  - state IDLE, `in_ready`=1.
  - internal column, row, bit and byte-address counters all 0.
  - shift register cleared.

State machine:
- **IDLE**
  - `in_ready`=1.
  - A beat accepted without `in_sof` is dropped; no counters change.
  - A beat accepted with `in_sof`:
    - `edge_count` and `frame_err` are cleared, then `edge_count` is loaded with `in_edge`.
    - The pixel is taken as (col 0, row 0).
    - Next state is RUN.
- **RUN**
  - `in_ready`=1.
  - Each accepted pixel sets bit (col mod 8) of the shift register.
  - `edge_count` increments when `in_edge`=1.
  - `col` increments; at col=IMG_W-1 it wraps to 0 and `row` increments.
  - When the accepted pixel has col mod 8 = 7, the completed byte is registered to `mem_wdata` and `mem_addr` = byte counter, with `mem_we`=1.
    - The byte counter then increments.
    - The shift register clears.
  - When the accepted pixel is (IMG_W-1, IMG_H-1), next state is DONE.
  - A beat with `in_sof` in RUN:
    - Sets `frame_err`.
    - Abandons the partial frame; no write of the partial byte.
    - Restarts the frame with this pixel as (0,0): counters reset, `edge_count` reloaded from `in_edge`.
    - Bytes already written are not revoked.
  - `in_eol` asserted at col ≠ IMG_W-1, or deasserted at col = IMG_W-1, sets `frame_err`. Counters are not realigned; position is driven by the counters only.
- **DONE**
  - `in_ready`=0.
  - `frame_done`=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- `frame_err` and `edge_count` hold their value from frame end until the next accepted `in_sof`.
- Asserting `reset` mid-frame returns to IDLE immediately and zeroes all outputs. The partial frame is lost.

## Timing
- `mem_we` is a registered one-cycle pulse, high in the cycle after the accept edge of the 8th pixel of a byte. `mem_addr`/`mem_wdata` are valid while `mem_we`=1.
- Byte addresses run 0 .. IMG_W*IMG_H/8-1 in order. Address = row*IMG_W/8 + col/8.
- The last byte's `mem_we` and `frame_done` are asserted in the same cycle, the one following acceptance of the final pixel.
- `edge_count` is updated in the cycle after each accept edge.
- Throughput is one pixel per cycle. A continuous frame occupies IMG_W*IMG_H accept cycles plus 1 DONE cycle, during which `in_ready`=0.
- `in_valid` gaps inside RUN stall all counters. No timeout.
- `in_ready` depends only on state (registered). There is no combinational path from `in_valid` to `in_ready`.

## Test plan
Default parameters (64×64) for all scenarios.
1. **Reset:** hold `reset`=0 → all outputs 0. Release → `in_ready`=1, no `mem_we`.
2. **Full frame:** 4096 continuous beats, `in_sof` on the first, `in_eol` on every 64th, `in_edge`=1 only at col 0 of every row.
   - 512 writes at addr 0..511.
   - Bytes at addr multiple of 8 are 0x01; all others 0x00.
   - `frame_done` pulses once, together with the addr-511 write.
   - `edge_count`=64, `frame_err`=0, `in_ready`=0 for that cycle.
3. **Pre-frame garbage and stalls:** 10 beats without `in_sof` (no writes), then a frame of all-ones with `in_valid` toggling every other cycle.
   - 512 writes of 0xFF.
   - `edge_count`=4096.
   - No counter advance on idle cycles.
4. **EOL error:** `in_eol` at col 62 of row 3 → `frame_err`=1 at frame end. Address sequence is unchanged; 512 writes still occur.
5. **Restart:** `in_sof` at pixel 100 of a frame, followed by 4096 clean pixels.
   - `frame_err`=1.
   - Writes resume at addr 0 after 12 earlier writes (addr 0..11).
   - Final `edge_count` reflects only the second frame.
6. **Reset mid-frame:** assert `reset` at pixel 2000 → outputs 0 immediately. A following clean frame completes with `frame_err`=0.

Source files
------------

// File: rtl/edge_frame_writer.sv
// Edge-map sink: packs a raster stream of binary edge pixels eight per byte (LSB first),
// writes the bytes to the frame RAM, and reports frame completion, framing errors and edge count.
module edge_frame_writer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_edge,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              frame_done,
    output logic              frame_err,
    output logic [CNT_W-1:0]  edge_count,
    output logic [1:0]        dbg_state
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_ready;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_shift;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_mem_wdata;
    logic               r_frame_done;
    logic               r_frame_err;
    logic [CNT_W-1:0]   r_edge_count;

    logic               w_hs;
    logic               w_pix;
    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic [ADDR_W-1:0]  w_addr;
    logic [7:0]         w_shift;
    logic               w_last_col;
    logic               w_last_pix;
    logic               w_byte_end;
    logic               w_err_base;

    // A pixel with in_sof is always position (0,0), whether it opens a frame or restarts one.
    always_comb begin
        w_hs       = in_valid & r_ready;
        w_pix      = w_hs & ((r_state == ST_RUN) | in_sof);
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_addr     = in_sof ? '0 : r_addr;
        w_shift    = (in_sof ? 8'd0 : r_shift) | (8'(in_edge) << w_col[2:0]);
        w_last_col = (w_col == COL_W'(IMG_W - 1));
        w_last_pix = w_last_col & (w_row == ROW_W'(IMG_H - 1));
        w_byte_end = (w_col[2:0] == 3'd7);
        w_err_base = (r_state == ST_IDLE) ? 1'b0 : (r_frame_err | in_sof);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_pix && w_last_pix) w_next = ST_DONE;
                else if (w_pix)          w_next = ST_RUN;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready      <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_shift      <= 8'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'd0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_edge_count <= '0;
        end else begin
            r_ready      <= (w_next != ST_DONE);
            r_frame_done <= (w_next == ST_DONE);
            r_mem_we     <= 1'b0;
            if (w_pix) begin
                r_col        <= w_last_col ? '0 : w_col + 1'b1;
                r_row        <= w_last_pix ? '0 : (w_last_col ? w_row + 1'b1 : w_row);
                r_edge_count <= (in_sof ? '0 : r_edge_count) + CNT_W'(in_edge);
                // Position comes from the counters only; a misplaced eol is flagged, never realigned.
                r_frame_err  <= w_err_base | (in_eol != w_last_col);
                if (w_byte_end) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_addr;
                    r_mem_wdata <= w_shift;
                    r_addr      <= w_addr + 1'b1;
                    r_shift     <= 8'd0;
                end else begin
                    r_addr      <= w_addr;
                    r_shift     <= w_shift;
                end
            end
        end
    end

    assign in_ready   = r_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign edge_count = r_edge_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_edge_frame_writer.sv
// Bench for edge_frame_writer: directed frame scenarios with random pixel content and gaps,
// checked against a pixel-index reference model and a write scoreboard.
module tb_edge_frame_writer;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 13;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTES = NPIX / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_edge = 1'b0;
    logic              in_sof = 1'b0;
    logic              in_eol = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              frame_done;
    logic              frame_err;
    logic [CNT_W-1:0]  edge_count;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    edge_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_edge(in_edge), .in_sof(in_sof), .in_eol(in_eol),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .frame_done(frame_done), .frame_err(frame_err), .edge_count(edge_count),
        .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_writes = 0;
    int n_done = 0;
    int m_dones = 0;
    logic [ADDR_W+7:0] exp_q[$];
    logic [CNT_W:0]    exp_done_q[$];

    bit m_active = 0;
    int m_p = 0;
    int m_cnt = 0;
    bit m_err = 0;
    bit m_fr[NPIX];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: a frame is a flat array of NPIX pixels; byte k is pixels 8k..8k+7.
    task automatic model_accept(input logic sof, input logic eol, input logic e);
        logic [7:0] b;
        if (!m_active && !sof) return;
        if (sof) begin
            m_err    = m_active;
            m_active = 1;
            m_p      = 0;
            m_cnt    = 0;
        end
        if (eol != ((m_p % IMG_W) == IMG_W - 1)) m_err = 1;
        m_fr[m_p] = e;
        m_cnt += int'(e);
        if (m_p % 8 == 7) begin
            for (int k = 0; k < 8; k++) b[k] = m_fr[m_p - 7 + k];
            exp_q.push_back({ADDR_W'(m_p / 8), b});
        end
        m_p++;
        if (m_p == NPIX) begin
            m_active = 0;
            m_dones++;
            exp_done_q.push_back({m_err, CNT_W'(m_cnt)});
        end
    endtask

    logic [ADDR_W+7:0] mon_w;
    logic [CNT_W:0]    mon_d;
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            if (mem_we) begin
                n_writes++;
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_w = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(mon_w[ADDR_W+7:8]));
                    check("wr_data", 32'(mem_wdata), 32'(mon_w[7:0]));
                end
            end
            if (frame_done) begin
                n_done++;
                check("done_ready_low", 32'(in_ready), 0);
                check("done_with_write", 32'(mem_we), 1);
                check("done_last_addr", 32'(mem_addr), NBYTES - 1);
                check("done_expected", 32'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    mon_d = exp_done_q.pop_front();
                    check("done_edge_count", 32'(edge_count), 32'(mon_d[CNT_W-1:0]));
                    check("done_frame_err", 32'(frame_err), 32'(mon_d[CNT_W]));
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // in_ready is registered, so its value between edges decides the next edge's accept.
    task automatic send_beat(input logic sof, input logic eol, input logic e);
        logic acc;
        int waited;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_sof = sof;
        in_eol = eol;
        in_edge = e;
        while (!acc && waited < 50) begin
            acc = in_ready;
            if (acc) model_accept(sof, eol, e);
            @(posedge clk);
            #1;
            waited++;
        end
        check("beat_accepted", 32'(acc), 1);
    endtask

    // mode: 0 edge at col 0, 1 all ones, 2 random. gap: 0 none, 1 one idle per beat, 2 random 0..2.
    task automatic run_frame(input int mode, input int gap, input int stop_at, input int bad_eol);
        int stop;
        int done0;
        int col;
        logic e;
        stop = (stop_at > 0) ? stop_at : NPIX;
        done0 = n_done;
        for (int i = 0; i < stop; i++) begin
            col = i % IMG_W;
            case (mode)
                0: e = (col == 0);
                1: e = 1'b1;
                default: e = 1'($urandom_range(0, 1));
            endcase
            send_beat(i == 0, (col == IMG_W - 1) ^ (i == bad_eol), e);
            if (gap == 1) idle(1);
            else if (gap == 2) idle($urandom_range(0, 2));
        end
        if (stop == NPIX) begin
            in_valid = 1'b0;
            for (int k = 0; k < 10 && n_done == done0; k++) begin
                @(posedge clk);
                #2;
            end
            check("frame_done_seen", 32'(n_done > done0), 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 0);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_err"}, 32'(frame_err), 0);
        check({tag, "_count"}, 32'(edge_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel_ready", 32'(in_ready), 1);
        check("rst_rel_we", 32'(mem_we), 0);

        w0 = n_writes;
        run_frame(0, 0, 0, -1);
        check("s2_writes", 32'(n_writes - w0), NBYTES);
        check("s2_edge_count", 32'(edge_count), IMG_H);
        check("s2_frame_err", 32'(frame_err), 0);

        w0 = n_writes;
        for (int i = 0; i < 10; i++)
            send_beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(2);
        check("s3_garbage_writes", 32'(n_writes - w0), 0);
        check("s3_garbage_count_held", 32'(edge_count), IMG_H);
        run_frame(1, 1, 0, -1);
        check("s3_writes", 32'(n_writes - w0), NBYTES);
        check("s3_edge_count", 32'(edge_count), NPIX);
        check("s3_frame_err", 32'(frame_err), 0);

        w0 = n_writes;
        run_frame(2, 0, 0, 3 * IMG_W + 62);
        check("s4_writes", 32'(n_writes - w0), NBYTES);
        check("s4_frame_err", 32'(frame_err), 1);

        w0 = n_writes;
        run_frame(2, 0, 100, -1);
        run_frame(0, 0, 0, -1);
        check("s5_writes", 32'(n_writes - w0), 12 + NBYTES);
        check("s5_frame_err", 32'(frame_err), 1);
        check("s5_edge_count", 32'(edge_count), IMG_H);

        run_frame(1, 0, 2000, -1);
        #2;
        check("s6_no_pending", 32'(exp_q.size()), 0);
        check("s6_count_before", 32'(edge_count), 2000);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_outputs_zero("s6_rst");
        m_active = 0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, 0, 0, -1);
        check("s6_frame_err", 32'(frame_err), 0);
        check("s6_edge_count", 32'(edge_count), IMG_H);

        run_frame(2, 2, 0, -1);

        idle(3);
        check("end_exp_q_empty", 32'(exp_q.size()), 0);
        check("end_done_q_empty", 32'(exp_done_q.size()), 0);
        check("end_done_count", 32'(n_done), 32'(m_dones));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
